// File: rtl/ar_tag_allocator.sv
// AR tag allocator: assigns a free internal tag to each AR request, forwards it as ARID,
// records the original ID per tag and announces each allocation to the reorder buffer.
module ar_tag_allocator #(
    parameter int ID_WIDTH    = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4,
    parameter int NUM_TAGS    = 16,
    localparam int TAG_W      = $clog2(NUM_TAGS),
    localparam int CNT_W      = $clog2(NUM_TAGS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ID_WIDTH-1:0]    in_id,
    input  logic [ADDR_WIDTH-1:0]  in_addr,
    input  logic [LEN_WIDTH-1:0]   in_len,
    input  logic [SIZE_WIDTH-1:0]  in_size,
    input  logic [BURST_WIDTH-1:0] in_burst,
    input  logic [QOS_WIDTH-1:0]   in_qos,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TAG_W-1:0]       out_id,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic [LEN_WIDTH-1:0]   out_len,
    output logic [SIZE_WIDTH-1:0]  out_size,
    output logic [BURST_WIDTH-1:0] out_burst,
    output logic [QOS_WIDTH-1:0]   out_qos,
    output logic                   alloc_valid,
    output logic [TAG_W-1:0]       alloc_tag,
    output logic [ID_WIDTH-1:0]    alloc_orig_id,
    output logic [LEN_WIDTH-1:0]   alloc_len,
    input  logic                   rel_valid,
    input  logic [TAG_W-1:0]       rel_tag,
    input  logic [TAG_W-1:0]       lookup_tag,
    output logic [ID_WIDTH-1:0]    lookup_orig_id,
    output logic [CNT_W-1:0]       outstanding,
    output logic                   rel_err
);

    logic [NUM_TAGS-1:0] busy_q;
    logic [ID_WIDTH-1:0] tbl_id [NUM_TAGS];
    logic [TAG_W-1:0]    free_tag;
    logic                have_free;
    logic                accept;
    logic                rel_hit;
    logic                rel_ok;
    logic                rel_bad;
    logic                out_valid_q;
    logic                alloc_valid_q;
    logic [CNT_W-1:0]    outstanding_q;
    logic                rel_err_q;

    // Lowest-index free tag wins: scan from the top so the last hit is the lowest.
    always_comb begin
        free_tag = '0;
        for (int unsigned i = NUM_TAGS; i > 0; i--) begin
            if (~busy_q[i-1]) begin
                free_tag = TAG_W'(i - 1);
            end
        end
    end

    assign have_free = |(~busy_q);
    assign in_ready  = have_free & (~out_valid_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign rel_hit   = busy_q[rel_tag];
    assign rel_ok    = rel_valid & rel_hit;
    assign rel_bad   = rel_valid & ~rel_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= '0;
            out_valid_q   <= 1'b0;
            out_id        <= '0;
            out_addr      <= '0;
            out_len       <= '0;
            out_size      <= '0;
            out_burst     <= '0;
            out_qos       <= '0;
            alloc_valid_q <= 1'b0;
            alloc_tag     <= '0;
            alloc_orig_id <= '0;
            alloc_len     <= '0;
            outstanding_q <= '0;
            rel_err_q     <= 1'b0;
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                tbl_id[i] <= '0;
            end
        end else begin
            // Accept only occurs when the output slot is empty or draining, so the
            // payload never changes under a stalled beat.
            if (accept) begin
                busy_q[free_tag] <= 1'b1;
                tbl_id[free_tag] <= in_id;
                out_id           <= free_tag;
                out_addr         <= in_addr;
                out_len          <= in_len;
                out_size         <= in_size;
                out_burst        <= in_burst;
                out_qos          <= in_qos;
                alloc_tag        <= free_tag;
                alloc_orig_id    <= in_id;
                alloc_len        <= in_len;
            end
            if (rel_ok) begin
                busy_q[rel_tag] <= 1'b0;
            end
            out_valid_q   <= accept | (out_valid_q & ~out_ready);
            alloc_valid_q <= accept;
            rel_err_q     <= rel_err_q | rel_bad;
            if (accept & ~rel_ok) begin
                outstanding_q <= outstanding_q + CNT_W'(1);
            end else if (rel_ok & ~accept) begin
                outstanding_q <= outstanding_q - CNT_W'(1);
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign alloc_valid    = alloc_valid_q;
    assign outstanding    = outstanding_q;
    assign rel_err        = rel_err_q;
    assign lookup_orig_id = tbl_id[lookup_tag];

endmodule

// File: tb/tb_ar_tag_allocator.sv
// Scoreboard bench for ar_tag_allocator: directed AR requests push expected beats and
// allocation notices; a monitor pops and compares them as the DUT presents them.
module tb_ar_tag_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_id;
    logic [31:0] in_addr;
    logic [7:0]  in_len;
    logic [2:0]  in_size;
    logic [1:0]  in_burst;
    logic [3:0]  in_qos;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_id;
    logic [31:0] out_addr;
    logic [7:0]  out_len;
    logic [2:0]  out_size;
    logic [1:0]  out_burst;
    logic [3:0]  out_qos;
    logic        alloc_valid;
    logic [3:0]  alloc_tag;
    logic [7:0]  alloc_orig_id;
    logic [7:0]  alloc_len;
    logic        rel_valid;
    logic [3:0]  rel_tag;
    logic [3:0]  lookup_tag;
    logic [7:0]  lookup_orig_id;
    logic [4:0]  outstanding;
    logic        rel_err;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  qos;
    } beat_t;

    typedef struct packed {
        logic [3:0] tag;
        logic [7:0] id;
        logic [7:0] len;
    } alloc_t;

    beat_t  out_q[$];
    alloc_t alloc_q[$];
    int     errors = 0;
    int     checks = 0;

    ar_tag_allocator #(
        .ID_WIDTH(8), .ADDR_WIDTH(32), .LEN_WIDTH(8), .SIZE_WIDTH(3),
        .BURST_WIDTH(2), .QOS_WIDTH(4), .NUM_TAGS(16)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_id(in_id), .in_addr(in_addr), .in_len(in_len),
        .in_size(in_size), .in_burst(in_burst), .in_qos(in_qos),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_addr(out_addr), .out_len(out_len),
        .out_size(out_size), .out_burst(out_burst), .out_qos(out_qos),
        .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
        .alloc_orig_id(alloc_orig_id), .alloc_len(alloc_len),
        .rel_valid(rel_valid), .rel_tag(rel_tag),
        .lookup_tag(lookup_tag), .lookup_orig_id(lookup_orig_id),
        .outstanding(outstanding), .rel_err(rel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: inputs change on negedge, so negedge+1 shows the handshake about to happen.
    beat_t  mon_exp_b, mon_act_b;
    alloc_t mon_exp_a, mon_act_a;
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            checks++;
            mon_act_b = {out_id, out_addr, out_len, out_size, out_burst, out_qos};
            if (out_q.size() == 0) begin
                errors++;
                $display("FAIL out_beat: got unexpected beat 0x%0h expected none", mon_act_b);
            end else begin
                mon_exp_b = out_q.pop_front();
                if (mon_act_b !== mon_exp_b) begin
                    errors++;
                    $display("FAIL out_beat: got 0x%0h expected 0x%0h", mon_act_b, mon_exp_b);
                end
            end
        end
        if (!rst && alloc_valid) begin
            checks++;
            mon_act_a = {alloc_tag, alloc_orig_id, alloc_len};
            if (alloc_q.size() == 0) begin
                errors++;
                $display("FAIL alloc: got unexpected pulse 0x%0h expected none", mon_act_a);
            end else begin
                mon_exp_a = alloc_q.pop_front();
                if (mon_act_a !== mon_exp_a) begin
                    errors++;
                    $display("FAIL alloc: got 0x%0h expected 0x%0h", mon_act_a, mon_exp_a);
                end
            end
        end
    end

    task automatic drive_payload(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        in_id    = id;
        in_addr  = addr;
        in_len   = len;
        in_size  = id[2:0];
        in_burst = id[4:3];
        in_qos   = id[7:4];
    endtask

    task automatic req(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [3:0] tag, input logic ordy, input logic rv, input logic [3:0] rt);
        @(negedge clk);
        in_valid  = 1'b1;
        drive_payload(id, addr, len);
        out_ready = ordy;
        rel_valid = rv;
        rel_tag   = rt;
        out_q.push_back({tag, addr, len, id[2:0], id[4:3], id[7:4]});
        alloc_q.push_back({tag, id, len});
        #1;
        for (int n = 0; n < 20 && !in_ready; n++) begin
            @(negedge clk);
            rel_valid = 1'b0;
            #1;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got in_ready=0 expected 1 for id 0x%0h", id);
            void'(out_q.pop_back());
            void'(alloc_q.pop_back());
            in_valid = 1'b0;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid  = 1'b0;
        rel_valid = 1'b0;
        out_ready = 1'b1;
        #1;
    endtask

    task automatic rel(input logic [3:0] t);
        @(negedge clk);
        in_valid  = 1'b0;
        rel_valid = 1'b1;
        rel_tag   = t;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        drive_payload(8'h00, 32'h0, 8'h0);
        out_ready  = 1'b1;
        rel_valid  = 1'b0;
        rel_tag    = '0;
        lookup_tag = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_alloc_valid", alloc_valid, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_rel_err", rel_err, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_lookup", lookup_orig_id, 0);

        // First request: tag 0, one-cycle latency.
        req(8'h5A, 32'h100, 8'd3, 4'd0, 1'b1, 1'b0, 4'd0);
        idle();
        check("t1_out_valid", out_valid, 1);
        check("t1_out_id", out_id, 0);
        check("t1_alloc_valid", alloc_valid, 1);
        check("t1_outstanding", outstanding, 1);
        check("t1_lookup", lookup_orig_id, 8'h5A);
        idle();
        check("t1_out_valid_drop", out_valid, 0);
        check("t1_alloc_pulse_end", alloc_valid, 0);
        rel(4'd0);
        idle();
        check("t1_released", outstanding, 0);

        // Fill all 16 tags back-to-back.
        for (int i = 0; i < 16; i++) begin
            req(8'(8'h10 + i), 32'(32'h2000 + i * 16), 8'(i), 4'(i), 1'b1, 1'b0, 4'd0);
        end
        @(negedge clk);
        in_valid = 1'b1;
        drive_payload(8'h20, 32'h2500, 8'd9);
        #1;
        check("t2_full_outstanding", outstanding, 16);
        check("t2_full_in_ready", in_ready, 0);
        @(negedge clk);
        #1;
        check("t2_stall_in_ready", in_ready, 0);

        // Release tag 5: eligible one cycle later.
        @(negedge clk);
        rel_valid = 1'b1;
        rel_tag   = 4'd5;
        #1;
        check("t3_rel_cycle_in_ready", in_ready, 0);
        req(8'h20, 32'h2500, 8'd9, 4'd5, 1'b1, 1'b0, 4'd0);
        idle();
        lookup_tag = 4'd5;
        #1;
        check("t3_outstanding", outstanding, 16);
        check("t3_lookup5", lookup_orig_id, 8'h20);

        // Fresh state, then stall a beat with out_ready low.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req(8'h30, 32'h0000, 8'd0, 4'd0, 1'b1, 1'b0, 4'd0);
        req(8'h31, 32'h0800, 8'd1, 4'd1, 1'b1, 1'b0, 4'd0);
        req(8'h32, 32'h1000, 8'd2, 4'd2, 1'b1, 1'b0, 4'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            #1;
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_id", out_id, 2);
            check("t4_hold_addr", out_addr, 32'h1000);
            check("t4_hold_in_ready", in_ready, 0);
        end
        req(8'h33, 32'h3000, 8'd7, 4'd3, 1'b1, 1'b0, 4'd0);
        idle();
        check("t4_passthru_valid", out_valid, 1);
        check("t4_passthru_id", out_id, 3);

        // Simultaneous allocate of tag 3 and release of tag 1.
        rel(4'd3);
        req(8'h40, 32'h4000, 8'd2, 4'd3, 1'b1, 1'b1, 4'd1);
        idle();
        check("t5_outstanding", outstanding, 3);
        req(8'h41, 32'h4100, 8'd4, 4'd1, 1'b1, 1'b0, 4'd0);
        req(8'h42, 32'h4200, 8'd5, 4'd4, 1'b1, 1'b0, 4'd0);
        idle();
        check("t5_outstanding_after", outstanding, 5);

        // Release of a free tag, then reset with a beat in flight.
        rel(4'd7);
        idle();
        check("t6_rel_err", rel_err, 1);
        check("t6_outstanding", outstanding, 5);
        idle();
        check("t6_rel_err_sticky", rel_err, 1);
        req(8'h50, 32'h5000, 8'd1, 4'd5, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("t6_inflight_valid", out_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        void'(out_q.pop_back());
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_outstanding", outstanding, 0);
        check("t6_rst_rel_err", rel_err, 0);
        check("t6_rst_alloc_valid", alloc_valid, 0);
        check("t6_rst_lookup5", lookup_orig_id, 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("t6_post_alloc_valid", alloc_valid, 0);
        check("t6_post_in_ready", in_ready, 1);
        req(8'h60, 32'h6000, 8'd6, 4'd0, 1'b1, 1'b0, 4'd0);
        idle();
        check("t6_post_outstanding", outstanding, 1);
        idle();
        idle();
        check("end_out_q_empty", out_q.size(), 0);
        check("end_alloc_q_empty", alloc_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
